egress_cpld_gen: RTL
====================

Name: egress_cpld_gen

Overview:
- Read-side counterpart of the ingress write-request distributor.
- Accepts parsed single-DW memory read requests that target the BAR register space, issues one register read, and builds the matching completion TLP.
- Emits that completion on the egress stream as one 128-bit beat.
- Handles one request at a time; sits between the ingress parser and the egress arbiter.

Parameters:
- PCIE_DATA_WIDTH, 128: egress data width. Fixed; the 3DW header plus 1 data DW fills exactly one beat.
- PCIE_DATA_KW, 16: byte-keep width (PCIE_DATA_WIDTH/8).
- RD_TIMEOUT, 255: maximum cycles to wait for rd_ack after rd_req.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- completer_id  in  16  own bus/dev/func
- rdreq_valid  in  1  read request valid
- rdreq_rdy  out  1  request accepted when valid&&rdy
- rdreq_req_id  in  16  requester ID
- rdreq_tag  in  8  request tag
- rdreq_tc  in  3  traffic class
- rdreq_attr  in  2  attributes
- rdreq_len  in  10  length in DW
- rdreq_addr  in  7  address[6:0]
- rdreq_channel  in  4  channel number
- rdreq_offset  in  4  register offset
- rd_req  out  1  register read strobe, one cycle
- rd_tdest  out  10  {1'b0, register[2:0], action[1:0], channel[3:0]}
- rd_ack  in  1  register data valid
- rd_tdata  in  32  register data
- cpl_data  out  128  completion beat
- cpl_keep  out  16  byte enables
- cpl_last  out  1  always 1 with cpl_valid
- cpl_valid  out  1  completion valid
- cpl_rdy  in  1  egress ready

Behaviour:
- Reset: async on rst_n low; state IDLE; every output 0 except rdreq_rdy, which is 1.
- FSM states: IDLE, RD, WAIT, SEND.
- IDLE: rdreq_rdy=1. On valid&&rdy, capture all request fields, then decode:
  - rdreq_len!=1: go to SEND with status UR (3'b001), no data.
  - Else, if the offset is mapped: go to RD.
  - Else (unmapped): go to SEND with data 32'h0000_0000, status SC.
- rdreq_rdy=0 in RD, WAIT and SEND.
- Read offset map:
  - 4'b0000: RX transferred length, tdest register/action {3'b010,2'b01}.
  - 4'b0001: TX transferred length, {3'b010,2'b00}.
  - Anything else is unmapped.
- RD: rd_req=1 for exactly one cycle with rd_tdest valid; rd_tdest holds until the next request. Go to WAIT; clear the timeout counter.
- WAIT:
  - rd_ack: latch rd_tdata, go to SEND.
  - Counter reaches RD_TIMEOUT without ack: data 32'hFFFF_FFFF, status SC, go to SEND.
  - rd_ack takes priority over timeout in the same cycle.
  - rd_ack outside WAIT is ignored.
- SEND: cpl_valid=1, cpl_last=1. cpl_data/cpl_keep are stable while valid && !rdy. On cpl_rdy, go to IDLE. The new request is accepted no earlier than the next cycle.
- Minimum latency: accept at T, rd_req at T+1, ack earliest T+2, cpl_valid at T+3.
- Beat layout (DW0 in [31:0]):
  - DW0: [31:29] fmt, 3'b010 for CplD or 3'b000 for Cpl(UR); [28:24]=5'b01010; [22:20]=TC; [13:12]=attr; [9:0] length, 1 for CplD or 0 for Cpl.
  - DW1: [31:16] completer_id; [15:13] status; [12] BCM=0; [11:0] byte count=12'd4.
  - DW2: [31:16] requester ID; [15:8] tag; [7]=0; [6:0] = rdreq_addr with bits [1:0] forced to 0.
  - DW3: read data. cpl_keep=16'hFFFF for CplD, 16'h0FFF for Cpl (DW3=0).
- Timeout counter: $clog2(RD_TIMEOUT+1) bits, saturating, cleared on entry to WAIT.
- Reset mid-operation: the in-flight request is dropped, no completion is emitted, and outputs return to reset values immediately.

Test Plan:
- Mapped read: offset 0, channel 3, tag 8'h2A, req_id 16'h0100, addr 7'h40. Expect rd_tdest=10'h123. Ack returns 32'h0000_1000 after 2 cycles. Expect one beat with DW0=32'h4A00_0001, DW1={completer_id,16'h0004}, DW2=32'h0100_2A40, DW3=32'h0000_1000, keep FFFF.
- Backpressure: hold cpl_rdy=0 for 5 cycles in SEND. cpl_data must stay stable and rdreq_rdy must stay 0. Release: one handshake, then rdreq_rdy=1 the next cycle.
- Timeout: never assert rd_ack. cpl_valid rises RD_TIMEOUT+1 cycles after rd_req, with DW3=32'hFFFF_FFFF. A late rd_ack after that is ignored.
- Unsupported: rdreq_len=2. No rd_req; Cpl with DW0=32'h0A00_0000, status 3'b001, keep 0FFF. Unmapped offset 4'b0111: no rd_req; CplD with data 0.
- Reset: assert rst_n low while in WAIT. All outputs go to 0 and rdreq_rdy to 1; no completion is emitted after release. Back-to-back requests complete in order, with the tags of each preserved.

Source files
------------

// File: rtl/egress_cpld_gen.sv
// Completion generator for single-DW BAR register reads: accepts one parsed
// read request, performs one register read and emits a one-beat 3DW completion.
module egress_cpld_gen #(
    parameter int PCIE_DATA_WIDTH = 128,
    parameter int PCIE_DATA_KW    = 16,
    parameter int RD_TIMEOUT      = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [15:0]                completer_id,
    input  logic                       rdreq_valid,
    output logic                       rdreq_rdy,
    input  logic [15:0]                rdreq_req_id,
    input  logic [7:0]                 rdreq_tag,
    input  logic [2:0]                 rdreq_tc,
    input  logic [1:0]                 rdreq_attr,
    input  logic [9:0]                 rdreq_len,
    input  logic [6:0]                 rdreq_addr,
    input  logic [3:0]                 rdreq_channel,
    input  logic [3:0]                 rdreq_offset,
    output logic                       rd_req,
    output logic [9:0]                 rd_tdest,
    input  logic                       rd_ack,
    input  logic [31:0]                rd_tdata,
    output logic [PCIE_DATA_WIDTH-1:0] cpl_data,
    output logic [PCIE_DATA_KW-1:0]    cpl_keep,
    output logic                       cpl_last,
    output logic                       cpl_valid,
    input  logic                       cpl_rdy
);

    localparam int CW = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RD, WAIT, SEND} state_t;

    state_t          state, state_nxt;
    logic [15:0]     req_id_q;
    logic [7:0]      tag_q;
    logic [2:0]      tc_q;
    logic [1:0]      attr_q;
    logic [6:0]      addr_q;
    logic            is_ur_q;
    logic [31:0]     data_q;
    logic [CW-1:0]   cnt_q;

    logic            req_mapped;
    logic            req_single;
    logic            timed_out;

    assign req_single = (rdreq_len == 10'd1);
    assign req_mapped = (rdreq_offset == 4'b0000) || (rdreq_offset == 4'b0001);
    // Fires on the cycle the count would reach RD_TIMEOUT, so SEND lands RD_TIMEOUT+1 cycles after rd_req
    assign timed_out  = (cnt_q == CW'(RD_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rdreq_rdy = 1'b0;
        rd_req    = 1'b0;
        cpl_valid = 1'b0;
        cpl_last  = 1'b0;
        case (state)
            IDLE: begin
                rdreq_rdy = 1'b1;
                if (rdreq_valid) begin
                    if (req_single && req_mapped) state_nxt = RD;
                    else                          state_nxt = SEND;
                end
            end
            RD: begin
                rd_req    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (rd_ack || timed_out) state_nxt = SEND;
            end
            SEND: begin
                cpl_valid = 1'b1;
                cpl_last  = 1'b1;
                if (cpl_rdy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_id_q <= '0;
            tag_q    <= '0;
            tc_q     <= '0;
            attr_q   <= '0;
            addr_q   <= '0;
            is_ur_q  <= 1'b0;
            data_q   <= '0;
            cnt_q    <= '0;
            rd_tdest <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rdreq_valid) begin
                        req_id_q <= rdreq_req_id;
                        tag_q    <= rdreq_tag;
                        tc_q     <= rdreq_tc;
                        attr_q   <= rdreq_attr;
                        addr_q   <= rdreq_addr;
                        is_ur_q  <= !req_single;
                        data_q   <= '0;
                        if (req_single && req_mapped)
                            rd_tdest <= {1'b0, 3'b010,
                                         (rdreq_offset == 4'b0000) ? 2'b01 : 2'b00,
                                         rdreq_channel};
                    end
                end
                RD: cnt_q <= '0;
                WAIT: begin
                    if (rd_ack)
                        data_q <= rd_tdata;
                    else if (timed_out)
                        data_q <= '1;
                    if (cnt_q != CW'(RD_TIMEOUT))
                        cnt_q <= cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    logic [31:0] dw0, dw1, dw2, dw3;

    always_comb begin
        dw0 = {is_ur_q ? 3'b000 : 3'b010, 5'b01010, 1'b0, tc_q, 6'b0, attr_q,
               2'b00, is_ur_q ? 10'd0 : 10'd1};
        dw1 = {completer_id, is_ur_q ? 3'b001 : 3'b000, 1'b0, 12'd4};
        dw2 = {req_id_q, tag_q, 1'b0, addr_q[6:2], 2'b00};
        dw3 = is_ur_q ? 32'h0 : data_q;
        cpl_data = '0;
        cpl_keep = '0;
        // Gated so every completion output reads zero outside SEND, including after reset
        if (state == SEND) begin
            cpl_data = {dw3, dw2, dw1, dw0};
            cpl_keep = is_ur_q ? 16'h0FFF : 16'hFFFF;
        end
    end

endmodule
